// File: rtl/wb_forward_unit.sv
// wb_forward_unit: writeback stage holding DEPTH in-flight register writes.
// Slot 0 is the youngest entry and slot DEPTH-1 the oldest. The oldest entry
// commits to the register file, pending results forward to both read ports,
// and the pipe freezes while the oldest entry waits on a memory load.
//
// Build option WB_FORWARD_EN:
//   defined   - ready pending results forward to fwd_d0/fwd_d1; only a
//               not-yet-ready youngest match raises fwd_hazard.
//   undefined - read ports pass rf_d0/rf_d1 straight through and any matching
//               pending write raises fwd_hazard.
//
// Handshake: the issue interface is accepted on a cycle with advance high,
// where advance = ~stall & ~stall_out acts as the ready; issue_valid &
// ~squash marks a real instruction, anything else enters as a bubble. With
// advance low nothing is accepted and the upstream must hold its request.
// The memory return (mem_rdy/mem_data) is valid-only with no back-pressure:
// it is consumed by the oldest waiting load, or dropped when none waits.

module wb_forward_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            squash,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [4:0]      issue_rd,
    input  logic [2:0]      issue_ld_code,
    input  logic [XLEN-1:0] alu_bits,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc_step,
    input  logic [XLEN-1:0] pc_addval,
    input  logic            mem_rdy,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] rf_d0,
    input  logic [XLEN-1:0] rf_d1,
    output logic [XLEN-1:0] fwd_d0,
    output logic [XLEN-1:0] fwd_d1,
    output logic            fwd_hazard,
    output logic            stall_out,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    localparam int OLDEST = DEPTH - 1;

    // Slot storage
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_wr;
    logic [DEPTH-1:0] r_rdy;
    logic [DEPTH-1:0] r_is_mem;
    logic [4:0]       r_rd   [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];

    // Next-state slot image
    logic [DEPTH-1:0] w_valid_n;
    logic [DEPTH-1:0] w_wr_n;
    logic [DEPTH-1:0] w_rdy_n;
    logic [DEPTH-1:0] w_is_mem_n;
    logic [4:0]       w_rd_n   [DEPTH];
    logic [XLEN-1:0]  w_data_n [DEPTH];

    // Control
    logic             w_stall_out;
    logic             w_advance;
    logic             w_iss_valid;
    logic             w_iss_rdy;
    logic             w_iss_is_mem;
    logic [XLEN-1:0]  w_iss_data;
    logic [DEPTH-1:0] w_fill_sel;
    logic [DEPTH-1:0] w_fill_post;

    // Forwarding match results
    logic             w_hit0;
    logic             w_hit1;
`ifdef WB_FORWARD_EN
    logic             w_hit_rdy0;
    logic             w_hit_rdy1;
    logic [XLEN-1:0]  w_hit_data0;
    logic [XLEN-1:0]  w_hit_data1;
`endif

    // The whole queue moves only when nobody freezes it and the oldest entry
    // is not blocked on memory.
    assign w_stall_out = r_valid[OLDEST] & ~r_rdy[OLDEST];
    assign w_advance   = ~stall & ~w_stall_out;
    assign w_iss_valid = issue_valid & ~squash;

    // Select the issuing instruction's result source from its load code.
    always_comb begin
        w_iss_data   = '0;
        w_iss_rdy    = 1'b1;
        w_iss_is_mem = 1'b0;
        case (issue_ld_code)
            3'b001: w_iss_data = alu_bits;
            3'b010: begin
                // Load data arrives later through the memory fill path.
                w_iss_data   = '0;
                w_iss_rdy    = 1'b0;
                w_iss_is_mem = 1'b1;
            end
            3'b011: w_iss_data = imm;
            3'b100: w_iss_data = pc_step;
            3'b101: w_iss_data = pc_addval;
            default: w_iss_data = pc_step;
        endcase
    end

    // Pick the oldest slot still waiting on load data as the fill target.
    always_comb begin
        logic found;
        found      = 1'b0;
        w_fill_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mem_rdy && !found && r_valid[i] && r_is_mem[i] && !r_rdy[i]) begin
                w_fill_sel[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Move the fill target to where that entry lives after this edge's shift.
    // The oldest slot cannot be a target while advancing, since a waiting
    // oldest load holds stall_out high.
    always_comb begin
        w_fill_post = '0;
        if (w_advance) begin
            for (int j = 1; j < DEPTH; j++) begin
                w_fill_post[j] = w_fill_sel[j-1];
            end
        end else begin
            w_fill_post = w_fill_sel;
        end
    end

    // Build the next slot image: hold, or shift toward the oldest slot and
    // load slot 0, then merge any memory fill.
    always_comb begin
        w_valid_n  = r_valid;
        w_wr_n     = r_wr;
        w_rdy_n    = r_rdy;
        w_is_mem_n = r_is_mem;
        for (int i = 0; i < DEPTH; i++) begin
            w_rd_n[i]   = r_rd[i];
            w_data_n[i] = r_data[i];
        end

        if (w_advance) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                w_valid_n[i]  = r_valid[i-1];
                w_wr_n[i]     = r_wr[i-1];
                w_rdy_n[i]    = r_rdy[i-1];
                w_is_mem_n[i] = r_is_mem[i-1];
                w_rd_n[i]     = r_rd[i-1];
                w_data_n[i]   = r_data[i-1];
            end
            w_valid_n[0]  = w_iss_valid;
            w_wr_n[0]     = w_iss_valid & issue_wr;
            w_rdy_n[0]    = w_iss_valid & w_iss_rdy;
            w_is_mem_n[0] = w_iss_valid & w_iss_is_mem;
            w_rd_n[0]     = w_iss_valid ? issue_rd : 5'd0;
            w_data_n[0]   = w_iss_valid ? w_iss_data : '0;
        end

        for (int j = 0; j < DEPTH; j++) begin
            if (w_fill_post[j]) begin
                w_rdy_n[j]  = 1'b1;
                w_data_n[j] = mem_data;
            end
        end
    end

    // Slot registers; reset empties the queue and drops pending loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr     <= '0;
            r_rdy    <= '0;
            r_is_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= 5'd0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid  <= w_valid_n;
            r_wr     <= w_wr_n;
            r_rdy    <= w_rdy_n;
            r_is_mem <= w_is_mem_n;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= w_rd_n[i];
                r_data[i] <= w_data_n[i];
            end
        end
    end

    // Commit: the oldest entry writes once, on the edge that shifts it out.
    assign stall_out = w_stall_out;
    assign wb_en     = w_advance & r_valid[OLDEST] & r_wr[OLDEST] &
                       r_rdy[OLDEST] & (r_rd[OLDEST] != 5'd0);
    assign wb_rd     = r_valid[OLDEST] ? r_rd[OLDEST] : 5'd0;
    assign wb_data   = r_valid[OLDEST] ? r_data[OLDEST] : '0;

    // Find the youngest pending write to each read address; x0 never matches.
    always_comb begin
        w_hit0 = 1'b0;
        w_hit1 = 1'b0;
`ifdef WB_FORWARD_EN
        w_hit_rdy0  = 1'b0;
        w_hit_rdy1  = 1'b0;
        w_hit_data0 = '0;
        w_hit_data1 = '0;
`endif
        // Walk oldest to youngest so the youngest match is the one kept.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_wr[i] && (r_rd[i] == rs1) && (rs1 != 5'd0)) begin
                w_hit0 = 1'b1;
`ifdef WB_FORWARD_EN
                w_hit_rdy0  = r_rdy[i];
                w_hit_data0 = r_data[i];
`endif
            end
            if (r_valid[i] && r_wr[i] && (r_rd[i] == rs2) && (rs2 != 5'd0)) begin
                w_hit1 = 1'b1;
`ifdef WB_FORWARD_EN
                w_hit_rdy1  = r_rdy[i];
                w_hit_data1 = r_data[i];
`endif
            end
        end
    end

    // Drive operand data and the hazard flag from the match results.
    always_comb begin
`ifdef WB_FORWARD_EN
        fwd_d0     = (w_hit0 && w_hit_rdy0) ? w_hit_data0 : rf_d0;
        fwd_d1     = (w_hit1 && w_hit_rdy1) ? w_hit_data1 : rf_d1;
        fwd_hazard = (w_hit0 & ~w_hit_rdy0) | (w_hit1 & ~w_hit_rdy1);
`else
        fwd_d0     = rf_d0;
        fwd_d1     = rf_d1;
        fwd_hazard = w_hit0 | w_hit1;
`endif
    end

endmodule

// File: tb/tb_wb_forward_unit.sv
// Testbench for wb_forward_unit (DEPTH=2, XLEN=32). Inputs change on the
// falling edge; outputs are sampled shortly after. A monitor pops expected
// commits from exp_q whenever wb_en is seen high.

module tb_wb_forward_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            squash;
    logic            issue_valid;
    logic            issue_wr;
    logic [4:0]      issue_rd;
    logic [2:0]      issue_ld_code;
    logic [XLEN-1:0] alu_bits;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_step;
    logic [XLEN-1:0] pc_addval;
    logic            mem_rdy;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rf_d0;
    logic [XLEN-1:0] rf_d1;
    logic [XLEN-1:0] fwd_d0;
    logic [XLEN-1:0] fwd_d1;
    logic            fwd_hazard;
    logic            stall_out;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    int checks   = 0;
    int failures = 0;
    logic [XLEN+4:0] exp_q[$];
    logic [XLEN+4:0] mon_exp;

    wb_forward_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .squash(squash),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_ld_code(issue_ld_code), .alu_bits(alu_bits), .imm(imm),
        .pc_step(pc_step), .pc_addval(pc_addval), .mem_rdy(mem_rdy),
        .mem_data(mem_data), .rs1(rs1), .rs2(rs2), .rf_d0(rf_d0), .rf_d1(rf_d1),
        .fwd_d0(fwd_d0), .fwd_d1(fwd_d1), .fwd_hazard(fwd_hazard),
        .stall_out(stall_out), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard monitor: every commit must match the head of exp_q.
    always begin
        @(negedge clk);
        #2;
        if (rst === 1'b0 && wb_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL commit_unexpected got rd=%0d data=%h required no commit", wb_rd, wb_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wb_rd, wb_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL commit_order got rd=%0d data=%h required rd=%0d data=%h",
                             wb_rd, wb_data, mon_exp[XLEN+4:XLEN], mon_exp[XLEN-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        issue_valid   = 1'b0;
        issue_wr      = 1'b0;
        issue_rd      = 5'd0;
        issue_ld_code = 3'b000;
        squash        = 1'b0;
        stall         = 1'b0;
        mem_rdy       = 1'b0;
    endtask

    // Place val on the source selected by code; other sources get noise.
    task automatic issue_op(input logic [4:0] rd, input logic [2:0] code,
                            input logic wr, input logic [XLEN-1:0] val,
                            output logic [XLEN-1:0] exp_d);
        issue_valid   = 1'b1;
        issue_wr      = wr;
        issue_rd      = rd;
        issue_ld_code = code;
        squash        = 1'b0;
        alu_bits      = $urandom;
        imm           = $urandom;
        pc_step       = $urandom;
        pc_addval     = $urandom;
        case (code)
            3'b001: alu_bits = val;
            3'b010: ;
            3'b011: imm = val;
            3'b100: pc_step = val;
            3'b101: pc_addval = val;
            default: pc_step = val;
        endcase
        exp_d = (code == 3'b010) ? '0 : val;
    endtask

    // Let the queue empty; an expired budget counts as a failure.
    task automatic drain();
        @(negedge clk);
        idle();
        for (int i = 0; i < 32 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        idle();
        rst   = 1'b1;
        rs1   = 5'd9;
        rs2   = 5'd17;
        rf_d0 = $urandom;
        rf_d1 = $urandom;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 7;
        if (wb_en !== 1'b0) begin failures++; $display("FAIL reset_wb_en got=%b required=0", wb_en); end
        if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd got=%0d required=0", wb_rd); end
        if (wb_data !== '0) begin failures++; $display("FAIL reset_wb_data got=%h required=0", wb_data); end
        if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall_out got=%b required=0", stall_out); end
        if (fwd_hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b required=0", fwd_hazard); end
        if (fwd_d0 !== rf_d0) begin failures++; $display("FAIL reset_fwd_d0 got=%h required=%h", fwd_d0, rf_d0); end
        if (fwd_d1 !== rf_d1) begin failures++; $display("FAIL reset_fwd_d1 got=%h required=%h", fwd_d1, rf_d1); end
    endtask

    task automatic test_alu_write();
        logic [XLEN-1:0] d;
        @(negedge clk);
        issue_op(5'd5, 3'b001, 1'b1, 32'h0000_1234, d);
        exp_q.push_back({5'd5, d});
        rs1   = 5'd5;
        rs2   = 5'd0;
        rf_d0 = $urandom;
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            idle();
            #1;
            checks++;
            if (wb_en !== (c == DEPTH)) begin
                failures++;
                $display("FAIL alu_wb_en cycle=%0d got=%b required=%b", c, wb_en, (c == DEPTH));
            end
            if (c == 1) begin
                checks += 2;
`ifdef WB_FORWARD_EN
                if (fwd_hazard !== 1'b0) begin failures++; $display("FAIL alu_fwd_hazard got=%b required=0", fwd_hazard); end
                if (fwd_d0 !== 32'h0000_1234) begin failures++; $display("FAIL alu_fwd_d0 got=%h required=00001234", fwd_d0); end
`else
                if (fwd_hazard !== 1'b1) begin failures++; $display("FAIL alu_fwd_hazard got=%b required=1", fwd_hazard); end
                if (fwd_d0 !== rf_d0) begin failures++; $display("FAIL alu_fwd_d0 got=%h required=%h", fwd_d0, rf_d0); end
`endif
            end
            if (c == DEPTH) begin
                checks += 2;
                if (wb_rd !== 5'd5) begin failures++; $display("FAIL alu_wb_rd got=%0d required=5", wb_rd); end
                if (wb_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_wb_data got=%h required=00001234", wb_data); end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (wb_en !== 1'b0) begin failures++; $display("FAIL alu_single_commit got=%b required=0", wb_en); end
        drain();
    endtask

    task automatic test_mem_load();
        logic [XLEN-1:0] d;
        logic exp_stall;
        logic exp_hz;
        @(negedge clk);
        issue_op(5'd7, 3'b010, 1'b1, '0, d);
        exp_q.push_back({5'd7, 32'hDEAD_BEEF});
        rs1   = 5'd7;
        rs2   = 5'd0;
        rf_d0 = $urandom;
        for (int c = 1; c <= DEPTH + 2; c++) begin
            @(negedge clk);
            idle();
            mem_rdy  = (c == DEPTH + 1);
            mem_data = (c == DEPTH + 1) ? 32'hDEAD_BEEF : $urandom;
            #1;
            exp_stall = (c >= DEPTH) && (c <= DEPTH + 1);
`ifdef WB_FORWARD_EN
            exp_hz = (c <= DEPTH + 1);
`else
            exp_hz = 1'b1;
`endif
            checks += 3;
            if (stall_out !== exp_stall) begin failures++; $display("FAIL mem_stall_out cycle=%0d got=%b required=%b", c, stall_out, exp_stall); end
            if (wb_en !== (c == DEPTH + 2)) begin failures++; $display("FAIL mem_wb_en cycle=%0d got=%b required=%b", c, wb_en, (c == DEPTH + 2)); end
            if (fwd_hazard !== exp_hz) begin failures++; $display("FAIL mem_hazard cycle=%0d got=%b required=%b", c, fwd_hazard, exp_hz); end
            if (c == DEPTH + 2) begin
                checks += 2;
                if (wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mem_wb_data got=%h required=deadbeef", wb_data); end
`ifdef WB_FORWARD_EN
                if (fwd_d0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mem_fwd_d0 got=%h required=deadbeef", fwd_d0); end
`else
                if (fwd_d0 !== rf_d0) begin failures++; $display("FAIL mem_fwd_d0 got=%h required=%h", fwd_d0, rf_d0); end
`endif
            end
        end
        drain();
    endtask

    task automatic test_mem_fill_shift();
        logic [XLEN-1:0] d;
        @(negedge clk);
        issue_op(5'd10, 3'b010, 1'b1, '0, d);
        exp_q.push_back({5'd10, 32'hCAFE_0001});
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            idle();
            mem_rdy  = (c == 1);
            mem_data = 32'hCAFE_0001;
            #1;
            checks += 2;
            if (stall_out !== 1'b0) begin failures++; $display("FAIL shift_fill_stall cycle=%0d got=%b required=0", c, stall_out); end
            if (wb_en !== (c == DEPTH)) begin failures++; $display("FAIL shift_fill_wb_en cycle=%0d got=%b required=%b", c, wb_en, (c == DEPTH)); end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d;
        logic exp_en;
        @(negedge clk);
        issue_op(5'd3, 3'b001, 1'b1, 32'd1, d);
        exp_q.push_back({5'd3, d});
        rs1   = 5'd3;
        rs2   = 5'd3;
        rf_d0 = $urandom;
        rf_d1 = $urandom;
        for (int c = 1; c <= DEPTH + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                issue_op(5'd3, 3'b001, 1'b1, 32'd2, d);
                exp_q.push_back({5'd3, d});
            end else begin
                idle();
            end
            #1;
            exp_en = (c == DEPTH) || (c == DEPTH + 1);
            checks++;
            if (wb_en !== exp_en) begin failures++; $display("FAIL b2b_wb_en cycle=%0d got=%b required=%b", c, wb_en, exp_en); end
            if (c == DEPTH) begin
                checks++;
                if (wb_data !== 32'd1) begin failures++; $display("FAIL b2b_first_data got=%h required=1", wb_data); end
            end
            if (c == DEPTH + 1) begin
                checks++;
                if (wb_data !== 32'd2) begin failures++; $display("FAIL b2b_second_data got=%h required=2", wb_data); end
            end
            if (c == 2) begin
                checks += 3;
`ifdef WB_FORWARD_EN
                if (fwd_d0 !== 32'd2) begin failures++; $display("FAIL b2b_fwd_d0 got=%h required=2", fwd_d0); end
                if (fwd_d1 !== 32'd2) begin failures++; $display("FAIL b2b_fwd_d1 got=%h required=2", fwd_d1); end
                if (fwd_hazard !== 1'b0) begin failures++; $display("FAIL b2b_hazard got=%b required=0", fwd_hazard); end
`else
                if (fwd_d0 !== rf_d0) begin failures++; $display("FAIL b2b_fwd_d0 got=%h required=%h", fwd_d0, rf_d0); end
                if (fwd_d1 !== rf_d1) begin failures++; $display("FAIL b2b_fwd_d1 got=%h required=%h", fwd_d1, rf_d1); end
                if (fwd_hazard !== 1'b1) begin failures++; $display("FAIL b2b_hazard got=%b required=1", fwd_hazard); end
`endif
            end
        end
        drain();
    endtask

    task automatic test_x0();
        logic [XLEN-1:0] d;
        @(negedge clk);
        issue_op(5'd0, 3'b001, 1'b1, 32'h0000_00FF, d);
        rs1   = 5'd0;
        rs2   = 5'd0;
        rf_d0 = $urandom;
        rf_d1 = $urandom;
        for (int c = 1; c <= DEPTH + 1; c++) begin
            @(negedge clk);
            idle();
            #1;
            checks += 3;
            if (wb_en !== 1'b0) begin failures++; $display("FAIL x0_wb_en cycle=%0d got=%b required=0", c, wb_en); end
            if (fwd_hazard !== 1'b0) begin failures++; $display("FAIL x0_hazard cycle=%0d got=%b required=0", c, fwd_hazard); end
            if (fwd_d1 !== rf_d1) begin failures++; $display("FAIL x0_fwd_d1 cycle=%0d got=%h required=%h", c, fwd_d1, rf_d1); end
            if (c == DEPTH) begin
                checks++;
                if (wb_data !== 32'h0000_00FF) begin failures++; $display("FAIL x0_wb_data got=%h required=000000ff", wb_data); end
            end
        end
        drain();
    endtask

    task automatic test_stall_squash();
        logic [XLEN-1:0] d;
        logic [XLEN-1:0] junk;
        @(negedge clk);
        issue_op(5'd4, 3'b001, 1'b1, 32'h0000_0044, d);
        exp_q.push_back({5'd4, d});
        rs1   = 5'd4;
        rf_d0 = $urandom;
        for (int c = 1; c <= DEPTH + 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                issue_op(5'd6, 3'b001, 1'b1, 32'h0000_0066, junk);
                stall  = 1'b1;
                squash = (c == 2);
            end else begin
                idle();
            end
            #1;
            checks += 2;
            if (wb_en !== (c == DEPTH + 4)) begin failures++; $display("FAIL stall_wb_en cycle=%0d got=%b required=%b", c, wb_en, (c == DEPTH + 4)); end
            if (stall_out !== 1'b0) begin failures++; $display("FAIL stall_stall_out cycle=%0d got=%b required=0", c, stall_out); end
            if (c <= 4) begin
                checks++;
`ifdef WB_FORWARD_EN
                if (fwd_d0 !== 32'h0000_0044) begin failures++; $display("FAIL stall_fwd_d0 cycle=%0d got=%h required=00000044", c, fwd_d0); end
`else
                if (fwd_hazard !== 1'b1) begin failures++; $display("FAIL stall_hazard cycle=%0d got=%b required=1", c, fwd_hazard); end
`endif
            end
        end
        drain();
    endtask

    task automatic test_squash();
        logic [XLEN-1:0] d;
        @(negedge clk);
        issue_op(5'd8, 3'b001, 1'b1, 32'h0000_0088, d);
        squash = 1'b1;
        @(negedge clk);
        issue_op(5'd9, 3'b001, 1'b1, 32'h0000_0099, d);
        exp_q.push_back({5'd9, d});
        for (int c = 1; c <= DEPTH + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) idle();
            #1;
            checks++;
            if (wb_en !== (c == DEPTH + 1)) begin failures++; $display("FAIL squash_wb_en cycle=%0d got=%b required=%b", c, wb_en, (c == DEPTH + 1)); end
        end
        drain();
    endtask

    task automatic test_load_codes();
        logic [2:0] codes [8];
        logic       wrs   [8];
        logic [XLEN-1:0] d;
        codes = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110, 3'b111, 3'b011};
        wrs   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue_op(5'(16 + i), codes[i], wrs[i], $urandom, d);
            if (wrs[i]) exp_q.push_back({5'(16 + i), d});
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        logic [XLEN-1:0] d;
        @(negedge clk);
        issue_op(5'd11, 3'b010, 1'b1, '0, d);
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            idle();
        end
        #1;
        checks++;
        if (stall_out !== 1'b1) begin failures++; $display("FAIL rst_stall_before got=%b required=1", stall_out); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin failures++; $display("FAIL rst_stall_after got=%b required=0", stall_out); end
        @(negedge clk);
        mem_rdy  = 1'b1;
        mem_data = 32'h0000_0BAD;
        @(negedge clk);
        mem_rdy = 1'b0;
        issue_op(5'd13, 3'b010, 1'b1, '0, d);
        exp_q.push_back({5'd13, 32'h1313_1313});
        for (int c = 1; c <= DEPTH; c++) begin
            @(negedge clk);
            idle();
        end
        #1;
        checks++;
        if (stall_out !== 1'b1) begin failures++; $display("FAIL rst_stale_fill got=%b required=1", stall_out); end
        @(negedge clk);
        mem_rdy  = 1'b1;
        mem_data = 32'h1313_1313;
        drain();
    endtask

    // Bound on total run time.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        idle();
        rst       = 1'b1;
        rs1       = 5'd0;
        rs2       = 5'd0;
        rf_d0     = '0;
        rf_d1     = '0;
        alu_bits  = '0;
        imm       = '0;
        pc_step   = '0;
        pc_addval = '0;
        mem_data  = '0;
        test_reset();
        test_alu_write();
        test_mem_load();
        test_mem_fill_shift();
        test_back_to_back();
        test_x0();
        test_stall_squash();
        test_squash();
        test_load_codes();
        test_reset_mid_stall();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_forward_unit.md
# wb_forward_unit

- Parametrised writeback stage for the core.
- Holds a DEPTH-deep queue of in-flight register writes between decode and the register file.
- Selects each write's data by load code and commits the oldest write to the register file.
- Forwards pending results to the two register read ports, flags load-use hazards, and stalls the pipe while a memory load is outstanding.

## Interface
Parameters:
- XLEN, 32, datapath width
- DEPTH, 2, pending-write slots (1..4); slot 0 youngest, slot DEPTH-1 oldest

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  external freeze (icache/hazard controller)
- squash  in  1  replace the issuing instruction with a bubble
- issue_valid  in  1  instruction entering slot 0
- issue_wr  in  1  instruction writes a register
- issue_rd  in  5  destination register
- issue_ld_code  in  3  001 ALU, 010 MEM, 011 IMM, 100 PC, 101 PC+IMM, other → PC
- alu_bits, imm, pc_step, pc_addval  in  XLEN each  candidate sources for the issuing instruction
- mem_rdy  in  1  dcache load data valid this cycle
- mem_data  in  XLEN  dcache load data
- rs1, rs2  in  5 each  decode read addresses
- rf_d0, rf_d1  in  XLEN each  register file read data
- fwd_d0, fwd_d1  out  XLEN each  forwarded operand data
- fwd_hazard  out  1  operand not yet available
- stall_out  out  1  oldest slot waiting on memory
- wb_en  out  1  register file write enable
- wb_rd  out  5  write address
- wb_data  out  XLEN  write data

## Operation
- Slot fields: valid, wr, rd, rdy, is_mem, data.
- advance = ~stall & ~stall_out. Slots shift toward DEPTH-1 only on advance.
- Slot 0 load on advance:
  - Normal issue: issue_valid & ~squash.
  - Data comes from the load-code mux.
  - MEM: rdy=0, is_mem=1, data=0. All other codes: rdy=1.
  - squash or ~issue_valid loads a bubble (valid=0).
- On stall, every slot holds and squash is ignored.
- Memory fill: on mem_rdy, the oldest slot with valid & is_mem & ~rdy takes data=mem_data and rdy=1.
  - Fill happens regardless of stall.
  - If it coincides with advance, the fill targets that entry's post-shift position.
  - mem_rdy with no waiting entry is dropped.
- stall_out = oldest.valid & ~oldest.rdy.
- wb_en = advance & oldest.valid & oldest.wr & oldest.rdy & (oldest.rd != 0). Each write commits exactly once.
- wb_rd/wb_data mirror the oldest slot and are 0 when it is invalid.
- Forwarding, per read port, combinational:
  - Find the youngest slot with valid & wr & rd == rsN & rsN != 0.
  - Match with rdy → fwd_dN = slot data.
  - Match without rdy → fwd_hazard=1, and fwd_dN = rf_dN.
  - No match → rf_dN.
- x0 is never forwarded and never written.

## Timing
- Reset: all slots invalid. wb_en=0, wb_rd=0, wb_data=0, stall_out=0, fwd_hazard=0. fwd_dN pass rf_dN.
- An instruction issued at edge n reaches wb at the cycle after edge n+DEPTH-1. Add 1 cycle per stalled cycle.
- Load latency is unbounded: stall_out holds until mem_rdy. Commit happens on the first advance after the fill.
- rst mid-stall clears pending loads. A later mem_rdy is dropped.
- Squash and stall in the same cycle: stall wins, nothing is inserted.
- Two slots writing the same rd: the younger slot forwards, and the older slot still commits first.

## Configuration
- WB_FORWARD_EN defined: forwarding as above.
- Undefined:
  - fwd_dN always equals rf_dN.
  - fwd_hazard=1 on any matching valid write slot, ready or not.
  - Commit and stall behaviour are unchanged.

## Test plan
- Reset, then issue ALU write x5=0x1234 → wb_en=1, wb_rd=5, wb_data=0x1234 exactly DEPTH cycles later.
- MEM load to x7, mem_rdy 3 cycles later with 0xDEADBEEF:
  - While the load is oldest, stall_out=1 and wb_en=0.
  - Commit on the next advance.
  - rs1=7 gives fwd_hazard=1 until fill.
- Back-to-back writes x3=1 then x3=2, rs1=3 → fwd_d0=2, then commits 1 then 2 in order.
- Issue x0=0xFF, rs2=0 → no forwarding, wb_en=0.
- stall held 4 cycles with squash pulsed → slots unchanged, no bubble inserted.
- WB_FORWARD_EN undefined: ALU write x9 pending, rs1=9 → fwd_hazard=1, fwd_d0=rf_d0.
